// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between instruction fetch and load/store.
// One access at a time: the request is latched at grant and completed with a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  output logic          mem_ready,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic          req_if_eff, req_mem_eff;
  logic          grant, grant_mem;

  // owner doubles as last_owner: it always holds the most recent grant
  always_comb begin
    state_nxt   = state;
    req_if_eff  = 1'b0;
    req_mem_eff = 1'b0;
    grant       = 1'b0;
    grant_mem   = 1'b0;
    ram_en      = 1'b0;
    if_ready    = 1'b0;
    mem_ready   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          if_ready    = ~owner;
          mem_ready   = owner;
          req_if_eff  = if_req & owner;
          req_mem_eff = mem_req & ~owner;
        end else begin
          req_if_eff  = if_req;
          req_mem_eff = mem_req;
        end
        grant     = req_if_eff | req_mem_eff;
        grant_mem = req_mem_eff & (~req_if_eff | ~owner);
        state_nxt = grant ? ACCESS : IDLE;
      end
      ACCESS: begin
        ram_en = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign ram_we    = ram_en & lat_we;
  assign ram_addr  = lat_addr;
  assign ram_wdata = lat_wdata;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else if (grant) begin
      owner     <= grant_mem;
      cnt       <= CNT_INIT;
      lat_we    <= grant_mem & mem_we;
      lat_addr  <= grant_mem ? mem_addr : if_addr;
      lat_wdata <= grant_mem ? mem_wdata : '0;
    end else if (state == ACCESS) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (!lat_we) begin
        // read data is valid only in the last access cycle
        if (owner) mem_rdata <= ram_rdata;
        else       if_rdata  <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios for the IF/MEM memory arbiter, then random traffic checked
// against a transaction-level timing model and a reference memory image.
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int AW      = 32;

  logic          clk, rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          stall_if, stall_mem, busy, owner;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Memory image: unwritten words come from a fixed pattern
  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      4:       return 32'h8C010004;
      8:       return 32'h11112222;
      12:      return 32'h0BADC0DE;
      64:      return 32'hCAFEF00D;
      default: return 32'hA5000000 ^ (idx * 32'h9E3779B1);
    endcase
  endfunction

  bit [31:0] ram_q  [1024];
  bit        ram_wr [1024];

  always_comb begin
    ram_rdata = 32'h0;
    if (ram_en) begin
      if (ram_wr[ram_addr[11:2]]) ram_rdata = ram_q[ram_addr[11:2]];
      else                        ram_rdata = init_word(int'(ram_addr[11:2]));
    end
  end

  always @(posedge clk) begin
    if (ram_en && ram_we) begin
      ram_q[ram_addr[11:2]]  <= ram_wdata;
      ram_wr[ram_addr[11:2]] <= 1'b1;
    end
  end

  // Reference memory used by the random phase
  bit [31:0] ref_q  [1024];
  bit        ref_wr [1024];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_wr[a[11:2]]) return ref_q[a[11:2]];
    return init_word(int'(a[11:2]));
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h400 + ($urandom_range(0, 15) << 2);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    if_req  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Transaction-level model state
  int          cyc, m_done;
  bit          m_active, m_owner, m_we;
  logic [31:0] m_addr, m_wdata, exp_if_rdata, exp_mem_rdata;
  bit          e_if_rdy, e_mem_rdy, e_done, r_if, r_mem, pick_mem;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;

    // Reset values; stalls follow the requests during reset
    @(negedge clk);
    if_req = 1'b1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_mem_ready", mem_ready, 1'b0);
    chk32("rst_ram_addr", ram_addr, 32'h0);
    chk32("rst_ram_wdata", ram_wdata, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_mem_rdata", mem_rdata, 32'h0);
    chk1("rst_stall_if", stall_if, 1'b1);
    chk1("rst_stall_mem", stall_mem, 1'b0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    chk1("t1_req_stall", stall_if, 1'b1);
    chk1("t1_req_busy", busy, 1'b0);
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      chk1($sformatf("t1_ram_en_%0d", k), ram_en, 1'b1);
      chk32($sformatf("t1_ram_addr_%0d", k), ram_addr, 32'h10);
      chk1($sformatf("t1_ram_we_%0d", k), ram_we, 1'b0);
      chk1($sformatf("t1_stall_%0d", k), stall_if, 1'b1);
      chk1($sformatf("t1_early_ready_%0d", k), if_ready, 1'b0);
    end
    @(negedge clk);
    chk1("t1_ready", if_ready, 1'b1);
    chk32("t1_rdata", if_rdata, 32'h8C010004);
    chk1("t1_done_ram_en", ram_en, 1'b0);
    chk1("t1_done_stall", stall_if, 1'b0);
    if_req = 1'b0;
    @(negedge clk);
    chk1("t1_idle_busy", busy, 1'b0);
    chk1("t1_single_pulse", if_ready, 1'b0);
    chk32("t1_rdata_hold", if_rdata, 32'h8C010004);

    // Load/fetch contention from reset: MEM first, IF back-to-back
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h20;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      chk1($sformatf("t2_owner_mem_%0d", k), owner, 1'b1);
      chk32($sformatf("t2_ram_addr_mem_%0d", k), ram_addr, 32'h100);
    end
    @(negedge clk);
    chk1("t2_mem_ready", mem_ready, 1'b1);
    chk1("t2_if_not_ready", if_ready, 1'b0);
    chk32("t2_mem_rdata", mem_rdata, 32'hCAFEF00D);
    chk1("t2_stall_if", stall_if, 1'b1);
    chk1("t2_stall_mem", stall_mem, 1'b0);
    mem_req = 1'b0;
    @(negedge clk);
    chk1("t2_no_gap", ram_en, 1'b1);
    chk1("t2_owner_if", owner, 1'b0);
    chk32("t2_ram_addr_if", ram_addr, 32'h20);
    @(negedge clk);
    chk1("t2_if_wait", if_ready, 1'b0);
    @(negedge clk);
    chk1("t2_if_ready", if_ready, 1'b1);
    chk32("t2_if_rdata", if_rdata, 32'h11112222);
    if_req = 1'b0;
    @(negedge clk);
    chk1("t2_idle", busy, 1'b0);

    // Store leaves mem_rdata untouched
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      chk1($sformatf("t3_ram_we_%0d", k), ram_we, 1'b1);
      chk32($sformatf("t3_ram_wdata_%0d", k), ram_wdata, 32'hDEADBEEF);
      chk32($sformatf("t3_ram_addr_%0d", k), ram_addr, 32'h200);
      chk1($sformatf("t3_stall_mem_%0d", k), stall_mem, 1'b1);
    end
    @(negedge clk);
    chk1("t3_mem_ready", mem_ready, 1'b1);
    chk32("t3_mem_rdata_kept", mem_rdata, 32'hCAFEF00D);
    chk1("t3_done_we", ram_we, 1'b0);
    chk32("t3_written", ram_q[128], 32'hDEADBEEF);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk1("t3_idle", busy, 1'b0);

    // Fairness under continuous contention
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      repeat (MEM_LAT + 1) @(negedge clk);
      chk1($sformatf("t4_owner_%0d", k), owner, (k % 2 == 0));
      chk1($sformatf("t4_ready_%0d", k), (k % 2 == 0) ? mem_ready : if_ready, 1'b1);
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    chk1("t4_idle", busy, 1'b0);

    // Reset during the second access cycle of a load
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    @(negedge clk);
    chk1("t5_access1", ram_en, 1'b1);
    @(posedge clk);
    #1;
    chk1("t5_access2", ram_en, 1'b1);
    rst = 1'b1;
    #1;
    chk1("t5_ram_en", ram_en, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    chk1("t5_owner", owner, 1'b0);
    chk1("t5_no_ready", mem_ready, 1'b0);
    chk32("t5_rdata_reset", mem_rdata, 32'h0);
    chk1("t5_stall_follow", stall_mem, 1'b1);
    @(negedge clk);
    chk1("t5_no_ready_rst", mem_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      chk1($sformatf("t5_reissue_en_%0d", k), ram_en, 1'b1);
      chk1($sformatf("t5_reissue_wait_%0d", k), mem_ready, 1'b0);
    end
    @(negedge clk);
    chk1("t5_reissue_ready", mem_ready, 1'b1);
    chk32("t5_reissue_rdata", mem_rdata, 32'hCAFEF00D);
    mem_req = 1'b0;
    @(negedge clk);

    // Dropped request and changed address during access
    if_req = 1'b1; if_addr = 32'h30;
    @(negedge clk);
    chk32("t6_ram_addr", ram_addr, 32'h30);
    if_req = 1'b0; if_addr = 32'h44;
    @(negedge clk);
    chk32("t6_ram_addr_latched", ram_addr, 32'h30);
    chk1("t6_ram_en", ram_en, 1'b1);
    chk1("t6_stall_dropped", stall_if, 1'b0);
    @(negedge clk);
    chk1("t6_ready", if_ready, 1'b1);
    chk32("t6_rdata", if_rdata, 32'h0BADC0DE);
    @(negedge clk);
    chk1("t6_single_pulse", if_ready, 1'b0);
    chk1("t6_idle", busy, 1'b0);

    // Random traffic against the transaction-level model
    do_reset();
    m_active = 1'b0; m_owner = 1'b0; m_we = 1'b0; m_done = 0;
    m_addr = '0; m_wdata = '0;
    exp_if_rdata = '0; exp_mem_rdata = '0;
    for (int i = 0; i < 1024; i++) ref_wr[i] = 1'b0;
    cyc = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      cyc++;
      e_done    = m_active && (cyc == m_done);
      e_if_rdy  = e_done && !m_owner;
      e_mem_rdy = e_done && m_owner;
      if (e_done) begin
        if (m_we) begin
          ref_q[m_addr[11:2]]  = m_wdata;
          ref_wr[m_addr[11:2]] = 1'b1;
        end else if (m_owner) begin
          exp_mem_rdata = ref_read(m_addr);
        end else begin
          exp_if_rdata = ref_read(m_addr);
        end
      end
      chk1("r_if_ready", if_ready, e_if_rdy);
      chk1("r_mem_ready", mem_ready, e_mem_rdy);
      chk1("r_busy", busy, m_active);
      chk1("r_owner", owner, m_owner);
      chk1("r_ram_en", ram_en, m_active && (cyc < m_done));
      if (m_active && (cyc < m_done)) begin
        chk32("r_ram_addr", ram_addr, m_addr);
        chk1("r_ram_we", ram_we, m_we);
        if (m_we) chk32("r_ram_wdata", ram_wdata, m_wdata);
      end
      chk32("r_if_rdata", if_rdata, exp_if_rdata);
      chk32("r_mem_rdata", mem_rdata, exp_mem_rdata);
      chk1("r_stall_if", stall_if, if_req && !e_if_rdy);
      chk1("r_stall_mem", stall_mem, mem_req && !e_mem_rdy);

      if (e_if_rdy)  if_req  = 1'b0;
      if (e_mem_rdy) mem_req = 1'b0;
      if (!if_req && ($urandom_range(0, 3) == 0)) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (!mem_req && ($urandom_range(0, 2) == 0)) begin
        mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
        mem_addr = rand_addr(); mem_wdata = $urandom();
      end

      // Arbitration decision taken at the coming clock edge
      if (!m_active || e_done) begin
        r_if  = if_req && !e_if_rdy;
        r_mem = mem_req && !e_mem_rdy;
        if (r_if || r_mem) begin
          pick_mem = r_mem && (!r_if || !m_owner);
          m_active = 1'b1;
          m_owner  = pick_mem;
          m_done   = cyc + MEM_LAT + 1;
          m_addr   = pick_mem ? mem_addr : if_addr;
          m_we     = pick_mem && mem_we;
          m_wdata  = mem_wdata;
        end else begin
          m_active = 1'b0;
        end
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    repeat (MEM_LAT + 3) @(negedge clk);
    chk1("end_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
